// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU time-sharing scheduler.
package alu_share_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // ALUControl codes understood by the shared ALU
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_ORR  = 3'b011;
   localparam logic [2:0] ALU_EOR  = 3'b111;
   localparam logic [2:0] ALU_FADD = 3'b100;
   localparam logic [2:0] ALU_FMUL = 3'b101;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_share_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the port that wins a tie;
// it flips to the other port each time advance is pulsed.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic       ptr_r;
   logic [1:0] gnt_s;
   logic       gnt_id_s;

   // Priority pointer: starts at port 0, toggles on every advance pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= 1'b0;
      end else if (advance) begin
         ptr_r <= ~ptr_r;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Grant decode: a lone requester always wins, a tie goes to the pointer
   always_comb begin
      gnt_s    = 2'b00;
      gnt_id_s = 1'b0;
      case (req)
         2'b01: begin
            gnt_s    = 2'b01;
            gnt_id_s = 1'b0;
         end
         2'b10: begin
            gnt_s    = 2'b10;
            gnt_id_s = 1'b1;
         end
         2'b11: begin
            if (ptr_r) begin
               gnt_s    = 2'b10;
               gnt_id_s = 1'b1;
            end else begin
               gnt_s    = 2'b01;
               gnt_id_s = 1'b0;
            end
         end
         default: begin
            gnt_s    = 2'b00;
            gnt_id_s = 1'b0;
         end
      endcase
   end

   assign gnt    = gnt_s;
   assign gnt_id = gnt_id_s;

endmodule

// File: rtl/alu_share_scheduler.sv
// Time-shares one combinational ALU between two requesters. Operands are
// held in registers for LAT cycles, then Result/ALUFlags are captured and
// returned on the granted port's response channel.
module alu_share_scheduler
   import alu_share_pkg::*;
#(
   parameter int LAT = 2,
   parameter int W   = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_ctrl,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_ctrl,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_ctrl,
   input  logic [W-1:0] alu_result,
   input  logic [3:0]   alu_flags,
   output logic         busy
);

   localparam int            CW       = $clog2(LAT) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

   state_t         state_r;
   logic [CW-1:0]  cnt_r;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [2:0]     ctrl_r;
   logic           gid_r;
   logic [W-1:0]   result_r;
   logic [3:0]     flags_r;
   logic [1:0]     rsp_valid_r;
   logic           busy_r;

   logic [1:0]     gnt_s;
   logic           gnt_id_s;
   logic           accept_s;
   logic           rsp_hs_s;
   logic [W-1:0]   sel_a_s;
   logic [W-1:0]   sel_b_s;
   logic [2:0]     sel_ctrl_s;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (reset_n),
      .req     ({req1_valid, req0_valid}),
      .advance (rsp_hs_s),
      .gnt     (gnt_s),
      .gnt_id  (gnt_id_s)
   );

   // A request is taken only while idle and some port is granted
   always_comb begin
      if (state_r == IDLE) begin
         accept_s = (gnt_s != 2'b00);
      end else begin
         accept_s = 1'b0;
      end
   end

   // Response handshake completes when the owning port takes the result
   always_comb begin
      if (state_r == RESP) begin
         rsp_hs_s = |(rsp_valid_r & {rsp1_ready, rsp0_ready});
      end else begin
         rsp_hs_s = 1'b0;
      end
   end

   // Route the granted port's operands toward the operand registers
   always_comb begin
      if (gnt_id_s) begin
         sel_a_s    = req1_a;
         sel_b_s    = req1_b;
         sel_ctrl_s = req1_ctrl;
      end else begin
         sel_a_s    = req0_a;
         sel_b_s    = req0_b;
         sel_ctrl_s = req0_ctrl;
      end
   end

   // Scheduler FSM: accept, hold ALU inputs for LAT cycles, capture, respond
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         a_r         <= '0;
         b_r         <= '0;
         ctrl_r      <= 3'b000;
         gid_r       <= 1'b0;
         result_r    <= '0;
         flags_r     <= 4'b0000;
         rsp_valid_r <= 2'b00;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r     <= sel_a_s;
                  b_r     <= sel_b_s;
                  ctrl_r  <= sel_ctrl_s;
                  gid_r   <= gnt_id_s;
                  cnt_r   <= CNT_LOAD;
                  busy_r  <= 1'b1;
                  state_r <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               if (cnt_r == '0) begin
                  result_r    <= alu_result;
                  flags_r     <= alu_flags;
                  rsp_valid_r <= gid_r ? 2'b10 : 2'b01;
                  state_r     <= RESP;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            RESP: begin
               if (rsp_hs_s) begin
                  rsp_valid_r <= 2'b00;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               rsp_valid_r <= 2'b00;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   // Ready is combinational on the grant but never shown while in reset
   assign req0_ready = reset_n & accept_s & gnt_s[0];
   assign req1_ready = reset_n & accept_s & gnt_s[1];

   assign rsp0_valid = rsp_valid_r[0];
   assign rsp1_valid = rsp_valid_r[1];
   assign rsp_result = result_r;
   assign rsp_flags  = flags_r;
   assign alu_a      = a_r;
   assign alu_b      = b_r;
   assign alu_ctrl   = ctrl_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Self-checking bench: a stub ALU feeds the scheduler, and a transaction-level
// model (request queues, grant rule, fixed latency) predicts every cycle.
module tb_alu_share_scheduler;
   import alu_share_pkg::*;

   localparam int LAT = 2;
   localparam int W   = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]   req0_ctrl, req1_ctrl;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp_result;
   logic [3:0]   rsp_flags;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [2:0]   alu_ctrl;
   logic [3:0]   alu_flags;
   logic         busy;

   always #5 clk = ~clk;

   alu_share_scheduler #(.LAT(LAT), .W(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .busy(busy)
   );

   typedef struct {
      logic [2:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   req_t        q0[$];
   req_t        q1[$];
   int          errors = 0;
   int          checks = 0;

   // transaction-level model state
   bit          m_busy;
   int          m_ptr, m_port, m_acc, cyc;
   logic [31:0] m_res, m_a, m_b;
   logic [2:0]  m_c;
   logic [3:0]  m_flg;
   logic [31:0] last_res [2];
   logic [3:0]  last_flg [2];
   int          acc_port[$];
   int          acc_cyc[$];
   int          rdy_mode;
   int          hold0;

   task automatic check_eq(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic real sp2real(input logic [31:0] v);
      logic [63:0] d;
      if (v[30:0] == 31'd0) return 0.0;
      d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Reference ALU behaviour: returns {N,Z,C,V, result}
   function automatic logic [35:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        cf, vf;
      r = 32'd0; cf = 1'b0; vf = 1'b0;
      case (c)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; cf = s[32];
            vf = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'b001: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; cf = s[32];
            vf = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'b010: r = a & b;
         3'b011: r = a | b;
         3'b111: r = a ^ b;
         3'b100: r = real2sp(sp2real(a) + sp2real(b));
         3'b101: r = real2sp(sp2real(a) * sp2real(b));
         default: r = 32'd0;
      endcase
      return {r[31], (r == 32'd0), cf, vf, r};
   endfunction

   // stub for the purely combinational ALU sitting behind the scheduler
   always_comb {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

   function automatic req_t rand_req();
      req_t        r;
      logic [2:0]  codes [6];
      codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b110};
      r.ctrl = codes[$urandom_range(0, 5)];
      r.a    = $urandom();
      r.b    = ($urandom_range(0, 3) == 0) ? r.a : $urandom();
      return r;
   endfunction

   task automatic drive_inputs();
      req_t r;
      if (q0.size() > 0) begin
         r = q0[0];
         req0_valid = 1'b1; req0_ctrl = r.ctrl; req0_a = r.a; req0_b = r.b;
      end else begin
         req0_valid = 1'b0; req0_ctrl = 3'b000; req0_a = '0; req0_b = '0;
      end
      if (q1.size() > 0) begin
         r = q1[0];
         req1_valid = 1'b1; req1_ctrl = r.ctrl; req1_a = r.a; req1_b = r.b;
      end else begin
         req1_valid = 1'b0; req1_ctrl = 3'b000; req1_a = '0; req1_b = '0;
      end
      if (hold0 > 0) rsp0_ready = 1'b0;
      else if (rdy_mode == 0) rsp0_ready = 1'b1;
      else rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   endtask

   // compare the DUT against the model for the current cycle, then advance the model
   task automatic model_check();
      int   w;
      bit   exp_v;
      req_t r;
      check_eq("busy", busy, m_busy);
      if (!m_busy) begin
         check_eq("rsp0_valid_idle", rsp0_valid, 1'b0);
         check_eq("rsp1_valid_idle", rsp1_valid, 1'b0);
         if (q0.size() == 0 && q1.size() == 0) begin
            check_eq("req0_ready_none", req0_ready, 1'b0);
            check_eq("req1_ready_none", req1_ready, 1'b0);
         end else begin
            w = (q0.size() > 0 && q1.size() > 0) ? m_ptr : ((q0.size() > 0) ? 0 : 1);
            check_eq("req0_ready", req0_ready, w == 0);
            check_eq("req1_ready", req1_ready, w == 1);
            if (w == 0) r = q0.pop_front();
            else r = q1.pop_front();
            {m_flg, m_res} = alu_fn(r.ctrl, r.a, r.b);
            m_a = r.a; m_b = r.b; m_c = r.ctrl;
            m_busy = 1'b1; m_port = w; m_acc = cyc + 1;
            acc_port.push_back(w);
            acc_cyc.push_back(cyc);
         end
      end else begin
         check_eq("req0_ready_busy", req0_ready, 1'b0);
         check_eq("req1_ready_busy", req1_ready, 1'b0);
         exp_v = (cyc >= m_acc + LAT);
         check_eq("rsp0_valid", rsp0_valid, exp_v && (m_port == 0));
         check_eq("rsp1_valid", rsp1_valid, exp_v && (m_port == 1));
         if (!exp_v) begin
            check_eq("alu_a", alu_a, m_a);
            check_eq("alu_b", alu_b, m_b);
            check_eq("alu_ctrl", alu_ctrl, m_c);
         end else begin
            check_eq("rsp_result", rsp_result, m_res);
            check_eq("rsp_flags", rsp_flags, m_flg);
            if ((m_port == 0) ? rsp0_ready : rsp1_ready) begin
               m_busy = 1'b0;
               m_ptr = 1 - m_ptr;
               last_res[m_port] = m_res;
               last_flg[m_port] = m_flg;
            end
            if (m_port == 0 && hold0 > 0) hold0--;
         end
      end
   endtask

   task automatic step(input bit rnd_push);
      if (rnd_push) begin
         if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
         if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
      end
      drive_inputs();
      @(negedge clk);
      cyc++;
      model_check();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < budget) begin
         step(1'b0);
         n++;
      end
      check_eq("drain_timeout", (q0.size() > 0 || q1.size() > 0 || m_busy), 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_rdy"}, {req1_ready, req0_ready}, 2'b00);
      check_eq({tag, "_rspv"}, {rsp1_valid, rsp0_valid}, 2'b00);
      check_eq({tag, "_res"}, rsp_result, 32'd0);
      check_eq({tag, "_flg"}, rsp_flags, 4'd0);
      check_eq({tag, "_alua"}, alu_a, 32'd0);
      check_eq({tag, "_alub"}, alu_b, 32'd0);
      check_eq({tag, "_aluc"}, alu_ctrl, 3'd0);
   endtask

   // asserted mid-cycle (between edges); pending queue entries stay visible
   task automatic apply_reset(input int cycles);
      reset_n = 1'b0;
      m_busy = 1'b0; m_ptr = 0; hold0 = 0;
      drive_inputs();
      repeat (cycles) begin
         @(negedge clk);
         cyc++;
         check_all_zero("reset");
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int n_before;
      reset_n = 1'b0; rdy_mode = 0; hold0 = 0; cyc = 0;
      m_busy = 1'b0; m_ptr = 0;
      last_res = '{32'd0, 32'd0};
      last_flg = '{4'd0, 4'd0};
      drive_inputs();
      apply_reset(3);

      // port 0 fadd 1.0 + 2.0
      q0.push_back('{ctrl: ALU_FADD, a: 32'h3F800000, b: 32'h40000000});
      drain(50);
      check_eq("fadd_result", last_res[0], 32'h40400000);
      check_eq("fadd_nz", last_flg[0][3:2], 2'b00);

      // port 1 fmul 2.0 * 3.0
      q1.push_back('{ctrl: ALU_FMUL, a: 32'h40000000, b: 32'h40400000});
      drain(50);
      check_eq("fmul_result", last_res[1], 32'h40C00000);

      // port 0 sub 5 - 5
      q0.push_back('{ctrl: ALU_SUB, a: 32'd5, b: 32'd5});
      drain(50);
      check_eq("sub_result", last_res[0], 32'd0);
      check_eq("sub_flags", last_flg[0], 4'b0110);

      // both ports, four requests each, from reset
      apply_reset(2);
      acc_port.delete(); acc_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{ctrl: ALU_ADD, a: $urandom(), b: $urandom()});
         q1.push_back('{ctrl: ALU_EOR, a: $urandom(), b: $urandom()});
      end
      drain(200);
      check_eq("alt_count", acc_port.size(), 8);
      for (int i = 0; i < acc_port.size(); i++) begin
         check_eq("alt_grant", acc_port[i], i % 2);
         if (i > 0) check_eq("alt_spacing", acc_cyc[i] - acc_cyc[i-1], LAT + 2);
      end

      // stall the port 0 response for five cycles while port 1 waits
      hold0 = 5;
      q0.push_back('{ctrl: ALU_ORR, a: 32'h1234_0000, b: 32'h0000_5678});
      q1.push_back('{ctrl: ALU_AND, a: 32'hFFFF_0000, b: 32'h0F0F_0F0F});
      drain(100);
      check_eq("hold_consumed", hold0, 0);
      check_eq("hold_result", last_res[0], 32'h1234_5678);

      // reset in the middle of EXEC, port 1 pending
      apply_reset(2);
      q0.push_back('{ctrl: ALU_ADD, a: 32'd7, b: 32'd9});
      step(1'b0);
      check_eq("pre_abort_busy_model", m_busy, 1'b1);
      step(1'b0);
      q1.push_back('{ctrl: ALU_ADD, a: 32'd100, b: 32'd23});
      apply_reset(2);
      n_before = acc_port.size();
      step(1'b0);
      check_eq("post_reset_grant", (acc_port.size() == n_before + 1) ? acc_port[$] : 9, 1);
      drain(50);
      check_eq("post_reset_result", last_res[1], 32'd123);

      // randomized traffic with random response back-pressure
      rdy_mode = 1;
      repeat (400) step(1'b1);
      drain(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
